// File: rtl/bin_frame_scaler.sv
// Nearest-neighbour down-scaler that sweeps a 1-bit frame buffer and emits a
// DST_W x DST_H pixel stream. Define SCALER_POPCOUNT_EN to enable o_ones_cnt.
module bin_frame_scaler #(
    parameter  int SRC_W = 640,
    parameter  int SRC_H = 480,
    parameter  int DST_W = 20,
    parameter  int DST_H = 20,
    localparam int CW    = $clog2(DST_W*DST_H+1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_start,
    output logic          o_busy,
    output logic [18:0]   o_addr_scale,
    input  logic          i_rd_data,
    output logic          o_end_scale,
    input  logic          i_finish,
    output logic          o_pix_data,
    output logic          o_pix_valid,
    input  logic          i_pix_ready,
    output logic          o_pix_eol,
    output logic          o_pix_eof,
    output logic          o_done,
    output logic [CW-1:0] o_ones_cnt
);
    localparam int AW = 19;
    localparam logic [AW-1:0] QX      = AW'(SRC_W / DST_W);
    localparam logic [AW-1:0] RX      = AW'(SRC_W % DST_W);
    localparam logic [AW-1:0] RY      = AW'(SRC_H % DST_H);
    localparam logic [AW-1:0] DWV     = AW'(DST_W);
    localparam logic [AW-1:0] DHV     = AW'(DST_H);
    localparam logic [AW-1:0] LAST_X  = AW'(DST_W - 1);
    localparam logic [AW-1:0] LAST_Y  = AW'(DST_H - 1);
    localparam logic [AW-1:0] STEP_Y0 = AW'((SRC_H / DST_H) * SRC_W);
    localparam logic [AW-1:0] STEP_Y1 = AW'((SRC_H / DST_H + 1) * SRC_W);
    localparam logic [AW-1:0] ONE     = AW'(1);
    localparam logic [AW-1:0] ZERO    = '0;

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_ENDSC} state_t;

    state_t        r_state;
    logic [AW-1:0] r_dx, r_dy, r_src_x, r_errx, r_erry, r_row_base;
    logic          r_rdv, r_rd_eol, r_rd_eof;
    logic          r_sk_v, r_sk_d, r_sk_eol, r_sk_eof;

    logic          w_out_free, w_accept, w_issue, w_last_x, w_last_y;
    logic          w_x_wrap, w_y_wrap;
    logic [AW-1:0] w_errx_sum, w_erry_sum, w_src_x_nxt, w_row_nxt;

    assign w_out_free  = !o_pix_valid || i_pix_ready;
    assign w_accept    = o_pix_valid && i_pix_ready;
    // A new read is only issued when its data is guaranteed a slot: the skid
    // entry is empty and the output register is free this cycle.
    assign w_issue     = (r_state == S_SCAN) && w_out_free && !r_sk_v;
    assign w_last_x    = (r_dx == LAST_X);
    assign w_last_y    = (r_dy == LAST_Y);
    assign w_errx_sum  = r_errx + RX;
    assign w_erry_sum  = r_erry + RY;
    assign w_x_wrap    = (w_errx_sum >= DWV);
    assign w_y_wrap    = (w_erry_sum >= DHV);
    assign w_src_x_nxt = r_src_x + QX + (w_x_wrap ? ONE : ZERO);
    assign w_row_nxt   = r_row_base + (w_y_wrap ? STEP_Y1 : STEP_Y0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            o_busy       <= 1'b0;
            o_addr_scale <= '0;
            o_end_scale  <= 1'b0;
            o_done       <= 1'b0;
            r_dx         <= '0;
            r_dy         <= '0;
            r_src_x      <= '0;
            r_errx       <= '0;
            r_erry       <= '0;
            r_row_base   <= '0;
        end else begin
            o_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state      <= S_SCAN;
                        o_busy       <= 1'b1;
                        o_addr_scale <= '0;
                        r_dx         <= '0;
                        r_dy         <= '0;
                        r_src_x      <= '0;
                        r_errx       <= '0;
                        r_erry       <= '0;
                        r_row_base   <= '0;
                    end
                end
                S_SCAN: begin
                    if (w_issue) begin
                        if (w_last_x) begin
                            r_dx    <= '0;
                            r_src_x <= '0;
                            r_errx  <= '0;
                            if (w_last_y) begin
                                r_state <= S_DRAIN;
                            end else begin
                                r_dy         <= r_dy + ONE;
                                r_erry       <= w_y_wrap ? w_erry_sum - DHV : w_erry_sum;
                                r_row_base   <= w_row_nxt;
                                o_addr_scale <= w_row_nxt;
                            end
                        end else begin
                            r_dx         <= r_dx + ONE;
                            r_errx       <= w_x_wrap ? w_errx_sum - DWV : w_errx_sum;
                            r_src_x      <= w_src_x_nxt;
                            o_addr_scale <= r_row_base + w_src_x_nxt;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_accept && o_pix_eof) begin
                        r_state     <= S_ENDSC;
                        o_end_scale <= 1'b1;
                    end
                end
                S_ENDSC: begin
                    if (i_finish) begin
                        r_state     <= S_IDLE;
                        o_end_scale <= 1'b0;
                        o_busy      <= 1'b0;
                        o_done      <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Read-data pipeline: skid entry (older) always drains ahead of fresh rd_data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdv       <= 1'b0;
            r_rd_eol    <= 1'b0;
            r_rd_eof    <= 1'b0;
            r_sk_v      <= 1'b0;
            r_sk_d      <= 1'b0;
            r_sk_eol    <= 1'b0;
            r_sk_eof    <= 1'b0;
            o_pix_valid <= 1'b0;
            o_pix_data  <= 1'b0;
            o_pix_eol   <= 1'b0;
            o_pix_eof   <= 1'b0;
        end else begin
            r_rdv    <= w_issue;
            r_rd_eol <= w_issue && w_last_x;
            r_rd_eof <= w_issue && w_last_x && w_last_y;
            if (w_out_free) begin
                if (r_sk_v) begin
                    o_pix_valid <= 1'b1;
                    o_pix_data  <= r_sk_d;
                    o_pix_eol   <= r_sk_eol;
                    o_pix_eof   <= r_sk_eof;
                    r_sk_v      <= r_rdv;
                    r_sk_d      <= i_rd_data;
                    r_sk_eol    <= r_rd_eol;
                    r_sk_eof    <= r_rd_eof;
                end else begin
                    o_pix_valid <= r_rdv;
                    o_pix_data  <= r_rdv && i_rd_data;
                    o_pix_eol   <= r_rd_eol;
                    o_pix_eof   <= r_rd_eof;
                end
            end else if (r_rdv) begin
                r_sk_v   <= 1'b1;
                r_sk_d   <= i_rd_data;
                r_sk_eol <= r_rd_eol;
                r_sk_eof <= r_rd_eof;
            end
        end
    end

`ifdef SCALER_POPCOUNT_EN
    logic [CW-1:0] r_ones;

    always_ff @(posedge clk) begin
        if (rst)
            r_ones <= '0;
        else if (r_state == S_IDLE && i_start)
            r_ones <= '0;
        else if (w_accept && o_pix_data)
            r_ones <= r_ones + CW'(1);
    end

    assign o_ones_cnt = r_ones;
`else
    assign o_ones_cnt = '0;
`endif

endmodule

// File: tb/tb_bin_frame_scaler.sv
// Directed bench for bin_frame_scaler: default 20x20 instance plus a 3x2 instance
// sharing one frame-buffer image.
module tb_bin_frame_scaler;
    localparam int SW = 640, SH = 480, DW = 20, DH = 20, NP = DW*DH;
    localparam int CW = $clog2(NP+1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, rd_data, finish, ready;
    logic          busy, end_scale, pix_data, pix_valid, pix_eol, pix_eof, done;
    logic [18:0]   addr;
    logic [CW-1:0] ones_cnt;

    logic          s_start, s_rd_data, s_finish, s_ready;
    logic          s_busy, s_end_scale, s_pix_data, s_pix_valid, s_pix_eol, s_pix_eof, s_done;
    logic [18:0]   s_addr;
    logic [2:0]    s_ones_cnt;

    bit mem [0:SW*SH-1];
    always @(posedge clk) rd_data <= mem[addr];
    always @(posedge clk) s_rd_data <= mem[s_addr];

    bin_frame_scaler u_dut (
        .clk(clk), .rst(rst), .i_start(start), .o_busy(busy), .o_addr_scale(addr),
        .i_rd_data(rd_data), .o_end_scale(end_scale), .i_finish(finish),
        .o_pix_data(pix_data), .o_pix_valid(pix_valid), .i_pix_ready(ready),
        .o_pix_eol(pix_eol), .o_pix_eof(pix_eof), .o_done(done), .o_ones_cnt(ones_cnt)
    );

    bin_frame_scaler #(.SRC_W(SW), .SRC_H(SH), .DST_W(3), .DST_H(2)) u_small (
        .clk(clk), .rst(rst), .i_start(s_start), .o_busy(s_busy), .o_addr_scale(s_addr),
        .i_rd_data(s_rd_data), .o_end_scale(s_end_scale), .i_finish(s_finish),
        .o_pix_data(s_pix_data), .o_pix_valid(s_pix_valid), .i_pix_ready(s_ready),
        .o_pix_eol(s_pix_eol), .o_pix_eof(s_pix_eof), .o_done(s_done), .o_ones_cnt(s_ones_cnt)
    );

    int checks = 0, errors = 0;

    function automatic int exp_addr(input int k);
        int dx, dy;
        dx = k % DW;
        dy = k / DW;
        return (dy*SH/DH)*SW + dx*SW/DW;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; finish = 1'b0; ready = 1'b1;
        s_start = 1'b0; s_finish = 1'b0; s_ready = 1'b1;
        tick; tick;
        checks++;
        if ({busy, pix_valid, pix_data, pix_eol, pix_eof, end_scale, done} !== 7'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 0000000",
                     {busy, pix_valid, pix_data, pix_eol, pix_eof, end_scale, done});
        end
        checks++;
        if (addr !== 19'd0) begin errors++; $display("FAIL reset_addr: got %0d want 0", addr); end
        checks++;
        if (ones_cnt !== '0) begin errors++; $display("FAIL reset_ones: got %0d want 0", ones_cnt); end
        rst = 1'b0;
        tick;
    endtask

    // Runs one default-size frame from IDLE; loop ends on the done cycle.
    task automatic run_frame(input string name, input bit full, input bit hold_start,
                             input bit fin_early, input int fin_delay);
        int k, esc, exp_ones;
        bit prev_stall, seen_done, ed;
        logic [18:0] prev_addr;
        logic [2:0] prev_out;
        k = 0; esc = 0; exp_ones = 0; prev_stall = 0; seen_done = 0;
        prev_addr = '0; prev_out = '0;
        for (int i = 0; i < NP; i++) exp_ones += int'(mem[exp_addr(i)]);
        start = 1'b1; finish = fin_early; ready = 1'b1;
        for (int c = 1; c <= 6000 && !seen_done; c++) begin
            tick;
            if (!hold_start) start = 1'b0;
            if (c == 1) begin
                checks++;
                if ({busy, addr} !== {1'b1, 19'd0}) begin
                    errors++;
                    $display("FAIL %s first_cycle: busy=%b addr=%0d want busy=1 addr=0", name, busy, addr);
                end
            end
            if (full && c <= NP) begin
                checks++;
                if (addr !== 19'(exp_addr(c-1))) begin
                    errors++;
                    $display("FAIL %s addr c=%0d: got %0d want %0d", name, c, addr, exp_addr(c-1));
                end
            end
            if (full && c >= 3 && c <= NP+2) begin
                checks++;
                if (pix_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL %s bubble c=%0d: pix_valid=%b want 1", name, c, pix_valid);
                end
            end
            if (prev_stall) begin
                checks++;
                if ({addr, pix_valid, pix_data, pix_eol, pix_eof} !== {prev_addr, 1'b1, prev_out}) begin
                    errors++;
                    $display("FAIL %s stall_hold c=%0d: addr=%0d v=%b got %b want addr=%0d %b",
                             name, c, addr, pix_valid, {pix_data, pix_eol, pix_eof}, prev_addr, prev_out);
                end
            end
            if (end_scale === 1'b1) esc++;
            if (full && c == NP+3) begin
                checks++;
                if ({end_scale, pix_valid} !== 2'b10) begin
                    errors++;
                    $display("FAIL %s end_scale_rise: end_scale=%b pix_valid=%b want 1 0", name, end_scale, pix_valid);
                end
            end
            if (done === 1'b1) begin
                seen_done = 1;
                checks++;
                if ({busy, end_scale} !== 2'b00 || esc != fin_delay) begin
                    errors++;
                    $display("FAIL %s done_cycle: busy=%b end_scale=%b esc_cycles=%0d want 0 0 %0d",
                             name, busy, end_scale, esc, fin_delay);
                end
            end
            ready = full ? 1'b1 : 1'($urandom_range(0, 1));
            finish = (esc == fin_delay) || (fin_early && esc == 0);
            if (pix_valid === 1'b1 && ready) begin
                checks++;
                if (k >= NP) begin
                    errors++;
                    $display("FAIL %s extra_pixel: got pixel %0d want only %0d", name, k, NP);
                end else begin
                    ed = mem[exp_addr(k)];
                    if ({pix_data, pix_eol, pix_eof} !== {ed, 1'(k % DW == DW-1), 1'(k == NP-1)}) begin
                        errors++;
                        $display("FAIL %s pixel %0d: got d/eol/eof=%b want %b", name, k,
                                 {pix_data, pix_eol, pix_eof}, {ed, 1'(k % DW == DW-1), 1'(k == NP-1)});
                    end
                end
                k++;
            end
            prev_stall = (pix_valid === 1'b1) && !ready;
            prev_addr = addr;
            prev_out = {pix_data, pix_eol, pix_eof};
        end
        finish = 1'b0;
        ready = 1'b1;
        checks++;
        if (!seen_done || k != NP) begin
            errors++;
            $display("FAIL %s completion: done_seen=%0d pixels=%0d want 1 %0d", name, seen_done, k, NP);
        end
`ifndef SCALER_POPCOUNT_EN
        exp_ones = 0;
`endif
        checks++;
        if (ones_cnt !== CW'(exp_ones)) begin
            errors++;
            $display("FAIL %s ones_cnt: got %0d want %0d", name, ones_cnt, exp_ones);
        end
    endtask

    task automatic test_single_pixel;
        for (int i = 0; i < SW*SH; i++) mem[i] = 1'b0;
        mem[456*SW + 608] = 1'b1;
        run_frame("single_pixel", 1'b1, 1'b0, 1'b0, 20);
        tick;
        checks++;
        if ({done, busy} !== 2'b00) begin
            errors++;
            $display("FAIL done_pulse: done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_backpressure;
        for (int i = 0; i < SW*SH; i++) mem[i] = 1'($urandom_range(0, 1));
        run_frame("backpressure", 1'b0, 1'b0, 1'b1, 20);
        tick;
    endtask

    task automatic test_reset_mid_scan;
        start = 1'b1;
        for (int c = 1; c <= 138; c++) begin
            tick;
            start = 1'b0;
        end
        checks++;
        if (addr !== 19'(exp_addr(137))) begin
            errors++;
            $display("FAIL mid_scan_addr: got %0d want %0d", addr, exp_addr(137));
        end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        checks++;
        if ({busy, pix_valid, pix_data, pix_eol, pix_eof, end_scale, done, addr, ones_cnt} !== '0) begin
            errors++;
            $display("FAIL mid_scan_reset: flags=%b addr=%0d ones=%0d want all 0",
                     {busy, pix_valid, pix_data, pix_eol, pix_eof, end_scale, done}, addr, ones_cnt);
        end
        tick;
        run_frame("after_reset", 1'b1, 1'b0, 1'b0, 5);
        tick;
    endtask

    task automatic test_start_held;
        run_frame("start_held", 1'b1, 1'b1, 1'b0, 3);
        tick;
        checks++;
        if ({busy, addr} !== {1'b1, 19'd0}) begin
            errors++;
            $display("FAIL restart_after_done: busy=%b addr=%0d want 1 0", busy, addr);
        end
        start = 1'b0;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        tick;
    endtask

    task automatic test_small_dst;
        int exp_a [6];
        bit pat [6];
        int k;
        bit seen_done;
        exp_a = '{0, 213, 426, 153600, 153813, 154026};
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) mem[exp_a[i]] = pat[i];
        k = 0; seen_done = 0;
        s_start = 1'b1;
        for (int c = 1; c <= 40 && !seen_done; c++) begin
            tick;
            s_start = 1'b0;
            if (c <= 6) begin
                checks++;
                if (s_addr !== 19'(exp_a[c-1])) begin
                    errors++;
                    $display("FAIL small_addr c=%0d: got %0d want %0d", c, s_addr, exp_a[c-1]);
                end
            end
            if (s_pix_valid === 1'b1) begin
                checks++;
                if (k >= 6 || {s_pix_data, s_pix_eol, s_pix_eof} !== {pat[k%6], 1'(k % 3 == 2), 1'(k == 5)}) begin
                    errors++;
                    $display("FAIL small_pixel %0d: got %b want %b", k,
                             {s_pix_data, s_pix_eol, s_pix_eof}, {pat[k%6], 1'(k % 3 == 2), 1'(k == 5)});
                end
                k++;
            end
            if (s_done === 1'b1) seen_done = 1;
            s_finish = s_end_scale;
        end
        s_finish = 1'b0;
        checks++;
        if (!seen_done || k != 6 || s_busy !== 1'b0) begin
            errors++;
            $display("FAIL small_completion: done_seen=%0d pixels=%0d busy=%b want 1 6 0", seen_done, k, s_busy);
        end
        tick;
    endtask

    initial begin
        test_reset;
        test_single_pixel;
        test_small_dst;
        test_backpressure;
        test_reset_mid_scan;
        test_start_held;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
